line_mem_responder: RTL and testbench
=====================================

Name: line_mem_responder

Overview:
- Main-memory responder on the far side of the data cache's refill/writeback interface.
- Accepts one line request at a time (read refill or dirty-line writeback), waits a programmable latency, then streams or absorbs LINE_WORDS beats with valid/ready handshakes.
- Backed by an internal word array.
- Has a combinational debug read port for the SDU, in the same way dra0/drd0 serve the CPU.

Parameters:
- ADDR_WIDTH, 10, word-address bits; array depth 2^ADDR_WIDTH words.
- LINE_WORDS_LOG, 2, log2 of words per line (4 words).
- LATENCY, 8, idle cycles between request accept and first data beat; 0 allowed.
- DATA_WIDTH, 32, word width.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous reset, active-low.
- req_valid  in  1  cache presents a line request.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_we  in  1  1 = writeback, 0 = refill read.
- req_addr  in  32  byte address; word index = req_addr[ADDR_WIDTH+1:2].
- rd_valid  out  1  read beat valid.
- rd_ready  in  1  cache accepts read beat.
- rd_data  out  DATA_WIDTH  read beat data.
- rd_last  out  1  final beat of read burst.
- wr_valid  in  1  cache presents write beat.
- wr_ready  out  1  responder accepts write beat.
- wr_data  in  DATA_WIDTH  write beat data.
- wr_done  out  1  one-cycle pulse after last write beat is stored.
- busy  out  1  high in any state except IDLE.
- dbg_addr  in  32  debug byte address.
- dbg_data  out  DATA_WIDTH  combinational array read at dbg_addr[ADDR_WIDTH+1:2].

Behaviour:
- Reset (async, rstn=0):
  - state=IDLE, counter=0, beat=0.
  - req_ready=1; rd_valid=rd_last=wr_ready=wr_done=busy=0.
  - Array contents are NOT cleared.
  - Reset mid-burst abandons the transfer; write beats already stored remain stored.
- States: IDLE, WAIT, RD_BURST, WR_BURST, WR_ACK.
- IDLE:
  - On req_valid&req_ready: latch req_we.
  - Latch line base = word index with low LINE_WORDS_LOG bits cleared; latch start offset.
  - Load counter=LATENCY.
  - If LATENCY==0, go directly to RD_BURST/WR_BURST; else go to WAIT.
- WAIT:
  - Decrement counter each cycle.
  - When counter==1, next state is RD_BURST (req_we=0) or WR_BURST (req_we=1).
  - Net effect: first rd_valid/wr_ready is high in the cycle after LATENCY+1 rising edges from accept.
- RD_BURST:
  - rd_valid=1; rd_data=array[base | beat_offset]; rd_last=1 when beat==LINE_WORDS-1.
  - Beat advances only on rd_valid&rd_ready; rd_data is held stable while rd_ready=0.
  - After the last handshake, go to IDLE.
- WR_BURST:
  - wr_ready=1; on wr_valid, array[base | beat_offset] <= wr_data and beat increments.
  - After the last beat, go to WR_ACK.
- WR_ACK: wr_done=1 for exactly one cycle, then go to IDLE.
- Beat counter is LINE_WORDS_LOG+1 bits; beat_offset = (start_offset + beat) mod LINE_WORDS, the low bits only.
- Addresses beyond the array depth wrap by truncation of upper bits. Offset never carries into line base.
- req_valid outside IDLE is ignored and not queued.
- wr_valid outside WR_BURST and rd_ready outside RD_BURST are ignored.
- Debug read is independent of state.
- When a write beat and dbg read target the same word in the same cycle, dbg_data shows the old value.

Optional Feature:
- Macro: MEM_CRITICAL_WORD_FIRST_EN.
- Defined:
  - start_offset = req_addr[LINE_WORDS_LOG+1:2] for reads.
  - Read burst begins at the requested word and wraps within the line.
  - Writebacks still start at offset 0.
- Undefined:
  - start_offset=0 for all requests.
  - Low word bits of req_addr are ignored.
  - Bursts always run word 0..LINE_WORDS-1.

Test Plan:
- Reset, then dbg_addr=0x0 preloaded 0x12345678 -> dbg_data=0x12345678; req_ready=1, busy=0, all valid outputs 0.
- Writeback req_addr=0x40, LATENCY=8, beats 0xA0..0xA3 with wr_valid=1 every cycle:
  - wr_ready first high 9 edges after accept.
  - wr_done pulses one cycle after the 4th beat.
  - dbg reads of 0x40/0x44/0x48/0x4C return 0xA0/0xA1/0xA2/0xA3.
- Refill req_addr=0x48 after the above, rd_ready toggling 1,0,1,1,0,1:
  - Macro off: beats 0xA0,0xA1,0xA2,0xA3, data held while rd_ready=0; rd_last only on 0xA3; req_ready high the cycle after.
  - Macro on: beats 0xA2,0xA3,0xA0,0xA1; rd_last on 0xA1.
- LATENCY=0, read req_addr=0x40 -> rd_valid high the cycle immediately after accept.
- rstn pulled low during RD_BURST beat 2 -> rd_valid=0 immediately (asynchronous); state IDLE; array unchanged; a new request completes normally.
- Address wrap: with ADDR_WIDTH=10, writeback to 0x1040 -> data lands at word index 0x010; dbg_addr=0x40 shows it.

Source files
------------

// File: rtl/line_mem_responder.sv
// Main-memory line responder behind the data cache refill/writeback port.
// Optional MEM_CRITICAL_WORD_FIRST_EN: read bursts start at the requested word.
module line_mem_responder #(
  parameter int ADDR_WIDTH     = 10,
  parameter int LINE_WORDS_LOG = 2,
  parameter int LATENCY        = 8,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_done,
  output logic                  busy,
  input  logic [31:0]           dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data
);

  localparam int DEPTH      = 1 << ADDR_WIDTH;
  localparam int LINE_WORDS = 1 << LINE_WORDS_LOG;
  localparam int BEAT_W     = LINE_WORDS_LOG + 1;
  localparam int BASE_W     = ADDR_WIDTH - LINE_WORDS_LOG;
  localparam int CNT_W      = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WAIT     = 3'd1;
  localparam logic [2:0] S_RD_BURST = 3'd2;
  localparam logic [2:0] S_WR_BURST = 3'd3;
  localparam logic [2:0] S_WR_ACK   = 3'd4;

  logic [2:0]                state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [BEAT_W-1:0]         beat_q, beat_d;
  logic [BASE_W-1:0]         base_q, base_d;
  logic [LINE_WORDS_LOG-1:0] start_q, start_d;
  logic                      we_q, we_d;

  logic [DATA_WIDTH-1:0]     mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0]     req_word;
  logic [ADDR_WIDTH-1:0]     dbg_word;
  logic [ADDR_WIDTH-1:0]     beat_word;
  logic [LINE_WORDS_LOG-1:0] beat_off;
  logic                      req_fire;
  logic                      rd_fire;
  logic                      wr_fire;
  logic                      last_beat;
  logic                      unused_addr_bits;

  // Upper address bits beyond the array simply wrap away.
  assign req_word         = req_addr[ADDR_WIDTH+1:2];
  assign dbg_word         = dbg_addr[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^{req_addr, dbg_addr};

  // Offset wraps inside the line and never carries into the base.
  assign beat_off  = start_q + beat_q[LINE_WORDS_LOG-1:0];
  assign beat_word = {base_q, beat_off};
  assign last_beat = (beat_q == BEAT_W'(LINE_WORDS - 1));

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rd_valid  = (state_q == S_RD_BURST);
  assign wr_ready  = (state_q == S_WR_BURST);
  assign wr_done   = (state_q == S_WR_ACK);
  assign rd_last   = rd_valid && last_beat;
  assign rd_data   = mem_q[beat_word];
  assign dbg_data  = mem_q[dbg_word];

  assign req_fire  = req_valid && req_ready;
  assign rd_fire   = rd_valid && rd_ready;
  assign wr_fire   = wr_ready && wr_valid;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    base_d  = base_q;
    start_d = start_q;
    we_d    = we_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_fire) begin
          we_d   = req_we;
          base_d = req_word[ADDR_WIDTH-1:LINE_WORDS_LOG];
          beat_d = '0;
          cnt_d  = CNT_W'(LATENCY);
`ifdef MEM_CRITICAL_WORD_FIRST_EN
          start_d = req_we ? '0 : req_word[LINE_WORDS_LOG-1:0];
`else
          start_d = '0;
`endif
          if (LATENCY == 0) begin
            state_d = req_we ? S_WR_BURST : S_RD_BURST;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = we_q ? S_WR_BURST : S_RD_BURST;
        end
      end
      S_RD_BURST: begin
        if (rd_fire) begin
          if (last_beat) begin
            beat_d  = '0;
            state_d = S_IDLE;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      S_WR_BURST: begin
        if (wr_fire) begin
          if (last_beat) begin
            beat_d  = '0;
            state_d = S_WR_ACK;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      S_WR_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is asynchronous.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      beat_q  <= '0;
      base_q  <= '0;
      start_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      base_q  <= base_d;
      start_q <= start_d;
      we_q    <= we_d;
    end
  end

  // NOTE: the array is deliberately not reset; contents survive rstn.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[beat_word] <= wr_data;
    end
  end

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench for line_mem_responder: LATENCY=8 instance plus a LATENCY=0 instance.
module tb_line_mem_responder;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;

  logic        req_valid = 0, req_we = 0, rd_ready = 0, wr_valid = 0;
  logic [31:0] req_addr = '0, wr_data = '0, dbg_addr = '0;
  logic        req_ready, rd_valid, rd_last, wr_ready, wr_done, busy;
  logic [31:0] rd_data, dbg_data;

  logic        req_valid0 = 0, req_we0 = 0, rd_ready0 = 0, wr_valid0 = 0;
  logic [31:0] req_addr0 = '0, wr_data0 = '0, dbg_addr0 = '0;
  logic        req_ready0, rd_valid0, rd_last0, wr_ready0, wr_done0, busy0;
  logic [31:0] rd_data0, dbg_data0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  line_mem_responder #(.ADDR_WIDTH(10), .LINE_WORDS_LOG(2), .LATENCY(8), .DATA_WIDTH(32)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_done(wr_done),
    .busy(busy), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  line_mem_responder #(.ADDR_WIDTH(10), .LINE_WORDS_LOG(2), .LATENCY(0), .DATA_WIDTH(32)) dut0 (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0), .req_addr(req_addr0),
    .rd_valid(rd_valid0), .rd_ready(rd_ready0), .rd_data(rd_data0), .rd_last(rd_last0),
    .wr_valid(wr_valid0), .wr_ready(wr_ready0), .wr_data(wr_data0), .wr_done(wr_done0),
    .busy(busy0), .dbg_addr(dbg_addr0), .dbg_data(dbg_data0)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Writeback a whole line into the LATENCY=8 instance without checking the protocol.
  task automatic wb_line(input logic [31:0] addr, input logic [31:0] d0);
    int n;
    req_valid = 1; req_we = 1; req_addr = addr; wr_valid = 1; wr_data = d0;
    step();
    req_valid = 0;
    for (int b = 0; b < 4; b++) begin
      n = 0;
      while (!wr_ready && n < 20) begin step(); n++; end
      if (n >= 20) begin
        total++; bad++;
        $display("FAIL wb_line_timeout: beat %0d never accepted", b);
      end
      wr_data = d0 + 32'(b);
      step();
    end
    wr_valid = 0;
    step();
  endtask

  task automatic test_reset();
    rstn = 0;
    #1;
    total++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || rd_valid !== 1'b0 || rd_last !== 1'b0 ||
        wr_ready !== 1'b0 || wr_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got rdy=%b busy=%b rv=%b rl=%b wr=%b wd=%b want 1 0 0 0 0 0",
               req_ready, busy, rd_valid, rd_last, wr_ready, wr_done);
    end
    step(); step();
    @(negedge clk); rstn = 1;
    step();
    dbg_addr = 32'h0; #1;
    total++;
    if (dbg_data !== 32'h12345678) begin
      bad++; $display("FAIL reset_dbg_keep: got %h want 12345678", dbg_data);
    end
    total++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || rd_valid !== 1'b0) begin
      bad++; $display("FAIL reset_idle: got rdy=%b busy=%b rv=%b want 1 0 0", req_ready, busy, rd_valid);
    end
  endtask

  task automatic test_writeback();
    int n;
    req_valid = 1; req_we = 1; req_addr = 32'h40; wr_valid = 1; wr_data = 32'hA0;
    step();
    req_valid = 0;
    total++;
    if (busy !== 1'b1 || req_ready !== 1'b0) begin
      bad++; $display("FAIL wb_busy: got busy=%b rdy=%b want 1 0", busy, req_ready);
    end
    n = 1;
    while (!wr_ready && n < 20) begin step(); n++; end
    total++;
    if (n !== 9) begin
      bad++; $display("FAIL wb_latency: got %0d edges want 9", n);
    end
    for (int b = 0; b < 4; b++) begin
      total++;
      if (wr_ready !== 1'b1 || wr_done !== 1'b0) begin
        bad++; $display("FAIL wb_beat%0d: got wr_ready=%b wr_done=%b want 1 0", b, wr_ready, wr_done);
      end
      wr_data = 32'hA0 + 32'(b);
      step();
    end
    wr_valid = 0;
    total++;
    if (wr_done !== 1'b1 || wr_ready !== 1'b0) begin
      bad++; $display("FAIL wb_done: got wr_done=%b wr_ready=%b want 1 0", wr_done, wr_ready);
    end
    step();
    total++;
    if (wr_done !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL wb_done_pulse: got wr_done=%b rdy=%b want 0 1", wr_done, req_ready);
    end
    for (int b = 0; b < 4; b++) begin
      dbg_addr = 32'h40 + 32'(4 * b); #1;
      total++;
      if (dbg_data !== 32'hA0 + 32'(b)) begin
        bad++; $display("FAIL wb_dbg%0d: got %h want %h", b, dbg_data, 32'hA0 + 32'(b));
      end
    end
  endtask

  task automatic test_refill();
    logic [5:0]  pat = 6'b101101;
    int          start, k, n;
    logic [31:0] exp_d;
    logic        exp_l;
`ifdef MEM_CRITICAL_WORD_FIRST_EN
    start = 2;
`else
    start = 0;
`endif
    req_valid = 1; req_we = 0; req_addr = 32'h48; rd_ready = 0;
    step();
    req_valid = 0;
    n = 1;
    while (!rd_valid && n < 20) begin step(); n++; end
    total++;
    if (n !== 9) begin
      bad++; $display("FAIL rd_latency: got %0d edges want 9", n);
    end
    k = 0;
    for (int c = 0; c < 6; c++) begin
      exp_d = 32'hA0 + 32'((start + k) % 4);
      exp_l = (k == 3);
      total++;
      if (rd_valid !== 1'b1 || rd_data !== exp_d || rd_last !== exp_l) begin
        bad++;
        $display("FAIL rd_cycle%0d: got v=%b d=%h l=%b want 1 %h %b", c, rd_valid, rd_data, rd_last, exp_d, exp_l);
      end
      rd_ready = pat[c];
      step();
      if (pat[c]) k++;
    end
    rd_ready = 0;
    total++;
    if (req_ready !== 1'b1 || rd_valid !== 1'b0) begin
      bad++; $display("FAIL rd_end: got rdy=%b rv=%b want 1 0", req_ready, rd_valid);
    end
  endtask

  task automatic test_latency0();
    req_valid0 = 1; req_we0 = 1; req_addr0 = 32'h40; wr_valid0 = 1; wr_data0 = 32'hB0;
    step();
    req_valid0 = 0;
    total++;
    if (wr_ready0 !== 1'b1) begin
      bad++; $display("FAIL lat0_wr_ready: got %b want 1", wr_ready0);
    end
    for (int b = 0; b < 4; b++) begin
      wr_data0 = 32'hB0 + 32'(b);
      step();
    end
    wr_valid0 = 0;
    total++;
    if (wr_done0 !== 1'b1) begin
      bad++; $display("FAIL lat0_wr_done: got %b want 1", wr_done0);
    end
    step();
    dbg_addr0 = 32'h44; #1;
    total++;
    if (dbg_data0 !== 32'hB1) begin
      bad++; $display("FAIL lat0_dbg: got %h want 000000b1", dbg_data0);
    end
    req_valid0 = 1; req_we0 = 0; req_addr0 = 32'h40; rd_ready0 = 1;
    step();
    req_valid0 = 0;
    total++;
    if (rd_valid0 !== 1'b1 || busy0 !== 1'b1) begin
      bad++; $display("FAIL lat0_rd_valid: got rv=%b busy=%b want 1 1", rd_valid0, busy0);
    end
    for (int b = 0; b < 4; b++) begin
      total++;
      if (rd_data0 !== 32'hB0 + 32'(b) || rd_last0 !== (b == 3)) begin
        bad++; $display("FAIL lat0_beat%0d: got d=%h l=%b want %h %b", b, rd_data0, rd_last0, 32'hB0 + 32'(b), b == 3);
      end
      step();
    end
    rd_ready0 = 0;
    total++;
    if (req_ready0 !== 1'b1 || rd_valid0 !== 1'b0) begin
      bad++; $display("FAIL lat0_end: got rdy=%b rv=%b want 1 0", req_ready0, rd_valid0);
    end
  endtask

  task automatic test_reset_mid_burst();
    int n;
    req_valid = 1; req_we = 0; req_addr = 32'h40; rd_ready = 0;
    step();
    req_valid = 0;
    n = 0;
    while (!rd_valid && n < 20) begin step(); n++; end
    rd_ready = 1;
    step(); step();
    total++;
    if (rd_valid !== 1'b1 || rd_data !== 32'hA2) begin
      bad++; $display("FAIL mid_beat2: got v=%b d=%h want 1 000000a2", rd_valid, rd_data);
    end
    rstn = 0; #1;
    total++;
    if (rd_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL mid_async: got rv=%b busy=%b rdy=%b want 0 0 1", rd_valid, busy, req_ready);
    end
    rd_ready = 0;
    @(negedge clk); rstn = 1;
    step();
    for (int b = 0; b < 4; b++) begin
      dbg_addr = 32'h40 + 32'(4 * b); #1;
      total++;
      if (dbg_data !== 32'hA0 + 32'(b)) begin
        bad++; $display("FAIL mid_array%0d: got %h want %h", b, dbg_data, 32'hA0 + 32'(b));
      end
    end
    req_valid = 1; req_we = 0; req_addr = 32'h40; rd_ready = 1;
    step();
    req_valid = 0;
    n = 1;
    while (!rd_valid && n < 20) begin step(); n++; end
    for (int b = 0; b < 4; b++) begin
      total++;
      if (rd_valid !== 1'b1 || rd_data !== 32'hA0 + 32'(b) || rd_last !== (b == 3)) begin
        bad++; $display("FAIL mid_redo%0d: got v=%b d=%h l=%b want 1 %h %b", b, rd_valid, rd_data, rd_last, 32'hA0 + 32'(b), b == 3);
      end
      step();
    end
    rd_ready = 0;
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL mid_redo_end: got rdy=%b want 1", req_ready);
    end
  endtask

  task automatic test_addr_wrap();
    int n;
    req_valid = 1; req_we = 1; req_addr = 32'h1040; wr_valid = 1; wr_data = 32'hC0;
    step();
    req_valid = 0;
    n = 1;
    while (!wr_ready && n < 20) begin step(); n++; end
    total++;
    if (n !== 9) begin
      bad++; $display("FAIL wrap_latency: got %0d edges want 9", n);
    end
    dbg_addr = 32'h40; #1;
    total++;
    if (dbg_data !== 32'hA0) begin
      bad++; $display("FAIL wrap_dbg_old: got %h want 000000a0", dbg_data);
    end
    step();
    total++;
    if (dbg_data !== 32'hC0) begin
      bad++; $display("FAIL wrap_dbg_new: got %h want 000000c0", dbg_data);
    end
    for (int b = 1; b < 4; b++) begin
      wr_data = 32'hC0 + 32'(b);
      step();
    end
    wr_valid = 0;
    step();
    dbg_addr = 32'h4C; #1;
    total++;
    if (dbg_data !== 32'hC3) begin
      bad++; $display("FAIL wrap_dbg_last: got %h want 000000c3", dbg_data);
    end
    dbg_addr = 32'h1044; #1;
    total++;
    if (dbg_data !== 32'hC1) begin
      bad++; $display("FAIL wrap_dbg_alias: got %h want 000000c1", dbg_data);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 0;
    step(); step();
    @(negedge clk); rstn = 1;
    step();
    wb_line(32'h0, 32'h12345678);
    test_reset();
    test_writeback();
    test_refill();
    test_latency0();
    test_reset_mid_burst();
    test_addr_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
